// File: rtl/button_event_decoder_if.sv
// Bundles the debounced button level and the decoded event pulses.
// The decoder attaches through the slave modport.
interface button_event_decoder_if;
  logic value_in;
  logic pressed;
  logic short_press;
  logic long_press;
  logic double_press;

  modport master (
    output value_in,
    input  pressed, short_press, long_press, double_press
  );

  modport slave (
    input  value_in,
    output pressed, short_press, long_press, double_press
  );
endinterface

// File: rtl/button_event_decoder.sv
// Turns an active-low debounced button level into single-clock short,
// long and double press events. One counter times both press and gap.
module button_event_decoder #(
  parameter int CLK_FREQ  = 50,
  parameter int LONG_TIME = 1000,
  parameter int GAP_TIME  = 300
) (
  input  logic                   clk,
  input  logic                   rst,
  button_event_decoder_if.slave  bus
);

  localparam int LONG_CNT = LONG_TIME * CLK_FREQ * 1000;
  localparam int GAP_CNT  = GAP_TIME * CLK_FREQ * 1000;
  localparam int MAX_CNT  = (LONG_CNT > GAP_CNT) ? LONG_CNT : GAP_CNT;
  localparam int CNT_W    = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(GAP_CNT - 1);

  typedef enum logic [2:0] {
    RELEASE_WAIT,
    IDLE,
    PRESS1,
    GAP,
    PRESS2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pressed_q;
  logic             short_q;
  logic             long_q;
  logic             double_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RELEASE_WAIT;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      double_q  <= 1'b0;
    end else begin
      pressed_q <= ~bus.value_in;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      double_q  <= 1'b0;
      case (state_q)
        // Entered after reset or a long press so a held button never re-triggers.
        RELEASE_WAIT: begin
          if (bus.value_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        IDLE: begin
          if (!bus.value_in) begin
            state_q <= PRESS1;
            cnt_q   <= '0;
          end
        end
        PRESS1: begin
          if (bus.value_in) begin
            state_q <= GAP;
            cnt_q   <= '0;
          end else if (cnt_q == LONG_TERM) begin
            long_q  <= 1'b1;
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // A re-press on the timeout edge still counts as a double press.
        GAP: begin
          if (!bus.value_in) begin
            state_q <= PRESS2;
            cnt_q   <= '0;
          end else if (cnt_q == GAP_TERM) begin
            short_q <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PRESS2: begin
          if (bus.value_in) begin
            double_q <= 1'b1;
            state_q  <= IDLE;
            cnt_q    <= '0;
          end
        end
        default: begin
          state_q <= RELEASE_WAIT;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.pressed      = pressed_q;
  assign bus.short_press  = short_q;
  assign bus.long_press   = long_q;
  assign bus.double_press = double_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG_CNT=2000, GAP_CNT=1000.
module tb_button_event_decoder;

  logic clk;
  logic rst;

  button_event_decoder_if bif ();

  button_event_decoder #(
    .CLK_FREQ  (1),
    .LONG_TIME (2),
    .GAP_TIME  (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Event monitor state, cleared per scenario
  int tk;
  int s_cnt, l_cnt, d_cnt;
  int first_at;
  int pressed_err;
  int multi_err;

  typedef struct {
    string name;
    int    p1;
    int    g;
    int    p2;
    int    exp_s;
    int    exp_l;
    int    exp_d;
    int    exp_first;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    tk = 0;
    s_cnt = 0;
    l_cnt = 0;
    d_cnt = 0;
    first_at = -1;
    pressed_err = 0;
    multi_err = 0;
  endtask

  // One clock: sample inputs before the edge, observe outputs 1 time unit after.
  task automatic tick();
    logic v;
    logic r;
    logic pexp;
    int   ev;
    v = bif.value_in;
    r = rst;
    @(posedge clk);
    #1;
    tk++;
    pexp = r ? 1'b0 : ~v;
    if (bif.pressed !== pexp) pressed_err++;
    ev = int'(bif.short_press) + int'(bif.long_press) + int'(bif.double_press);
    if (ev > 1) multi_err++;
    if (ev > 0 && first_at < 0) first_at = tk;
    if (bif.short_press)  s_cnt++;
    if (bif.long_press)   l_cnt++;
    if (bif.double_press) d_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_vec(input vec_t v);
    clear_mon();
    bif.value_in = 1'b0;
    ticks(v.p1);
    bif.value_in = 1'b1;
    if (v.g > 0) begin
      ticks(v.g);
      bif.value_in = 1'b0;
      ticks(v.p2);
      bif.value_in = 1'b1;
    end
    ticks(1200);
    chk({v.name, " short"},   s_cnt, v.exp_s);
    chk({v.name, " long"},    l_cnt, v.exp_l);
    chk({v.name, " double"},  d_cnt, v.exp_d);
    chk({v.name, " when"},    first_at, v.exp_first);
    chk({v.name, " pressed"}, pressed_err, 0);
    chk({v.name, " onehot"},  multi_err, 0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clear_mon();

    // Ticks counted from the press being driven; event tick = observed cycle.
    vecs.push_back('{"short",      500,    0,   0, 1, 0, 0, 1501});
    vecs.push_back('{"long",      5000,    0,   0, 0, 1, 0, 2001});
    vecs.push_back('{"double",     300,  400, 200, 0, 0, 1,  901});
    vecs.push_back('{"dbl_edge",   300, 1000, 200, 0, 0, 1, 1501});
    vecs.push_back('{"rel_at_thr",2000,    0,   0, 1, 0, 0, 3001});
    vecs.push_back('{"rel_after", 2001,    0,   0, 0, 1, 0, 2001});
    vecs.push_back('{"gap_miss",   300, 1001, 200, 2, 0, 0, 1301});

    // Reset with button released
    rst = 1'b1;
    bif.value_in = 1'b1;
    ticks(3);
    chk("rst pressed", int'(bif.pressed),      0);
    chk("rst short",   int'(bif.short_press),  0);
    chk("rst long",    int'(bif.long_press),   0);
    chk("rst double",  int'(bif.double_press), 0);
    rst = 1'b0;
    ticks(1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Button held through reset
    clear_mon();
    bif.value_in = 1'b0;
    rst = 1'b1;
    ticks(3);
    chk("held rst pressed", int'(bif.pressed), 0);
    rst = 1'b0;
    ticks(3000);
    chk("held events", s_cnt + l_cnt + d_cnt, 0);
    chk("held pressed", int'(bif.pressed), 1);
    bif.value_in = 1'b1;
    ticks(1200);
    chk("held release events", s_cnt + l_cnt + d_cnt, 0);
    chk("held pressed_err", pressed_err, 0);
    run_vec(vecs[0]);

    // Reset asserted partway through the release gap
    clear_mon();
    bif.value_in = 1'b0;
    ticks(300);
    bif.value_in = 1'b1;
    ticks(500);
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    ticks(1500);
    chk("gap rst events", s_cnt + l_cnt + d_cnt, 0);
    chk("gap rst pressed", pressed_err, 0);

    // Normal operation resumes after the aborted gap
    run_vec(vecs[2]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Classifies the debounced push-button level produced by the debouncer stage into single-cycle command events: short press, long press and double press. Sits directly downstream of the debouncer and upstream of the master/slave control logic, which consumes the one-clock event pulses. The button level is active-low: 1 means released, 0 means pressed.

## Interface
- CLK_FREQ, 50: clock frequency in MHz (integer).
- LONG_TIME, 1000: long-press threshold in ms.
- GAP_TIME, 300: maximum release gap for a double press, in ms.
- Derived: LONG_CNT = LONG_TIME*CLK_FREQ*1000; GAP_CNT = GAP_TIME*CLK_FREQ*1000; counter width = $clog2(max(LONG_CNT,GAP_CNT)).

- clk  input  1  system clock; one clock domain.
- rst  input  1  synchronous, active-high reset.
- value_in  input  1  debounced button level, synchronous to clk; 0 = pressed.
- pressed  output  1  registered ~value_in.
- short_press  output  1  one-clock pulse: single press shorter than LONG_CNT with no second press inside GAP_CNT.
- long_press  output  1  one-clock pulse: press held for LONG_CNT clocks.
- double_press  output  1  one-clock pulse: second press began within GAP_CNT of the first release.

## Operation
- States: RELEASE_WAIT, IDLE, PRESS1, GAP, PRESS2. Single counter cnt; it is cleared on every state change.
- RELEASE_WAIT: if value_in == 1, go to IDLE. This state absorbs a button that is held through reset, or after a long press.
- IDLE: if value_in == 0, go to PRESS1 with cnt = 0.
- PRESS1:
  - If value_in == 1, go to GAP.
  - Else if cnt == LONG_CNT-1, pulse long_press and go to RELEASE_WAIT.
  - Else cnt++.
- GAP:
  - If value_in == 0, go to PRESS2. A re-press takes priority over timeout on the same clock.
  - Else if cnt == GAP_CNT-1, pulse short_press and go to IDLE.
  - Else cnt++.
- PRESS2: if value_in == 1, pulse double_press and go to IDLE. Hold duration in PRESS2 is not timed; no long press is detected here.
- At most one event output is high in any cycle.
- No event is ever repeated while the button stays held.
- cnt never exceeds its terminal value and never wraps.

## Timing
- Reset:
  - State = RELEASE_WAIT, cnt = 0.
  - pressed, short_press, long_press and double_press are all 0 in the cycle after the rst posedge.
  - rst asserted mid-operation aborts any pending event; no pulse is emitted.
- All outputs are registered and each event pulse is exactly one clock wide.
- Let t0 be the posedge at which value_in = 0 is first sampled in IDLE.
  - long_press is high in the cycle after posedge t0+LONG_CNT, if value_in stayed 0 through that posedge.
  - A release sampled at posedge t0+LONG_CNT, which is the same edge as the threshold, yields GAP. It does not yield long_press.
- Let t1 be the posedge at which the release is sampled in PRESS1.
  - short_press is high in the cycle after posedge t1+GAP_CNT, if no press was sampled at t1+1 through t1+GAP_CNT.
  - A press sampled at t1+GAP_CNT yields PRESS2, not short_press.
- double_press is high in the cycle after the posedge that samples the second release.
- pressed follows value_in with a 1-clock latency.

## Test plan
All scenarios use CLK_FREQ=1, LONG_TIME=2, GAP_TIME=1, so LONG_CNT=2000 and GAP_CNT=1000.

- **Reset:** rst high for 3 clocks with value_in=1 → all outputs 0; after rst deasserts, state reaches IDLE in 1 clock.
- **Short press:** press for 500 clocks, then release → exactly one short_press pulse, 1000 clocks after the release edge; no other events.
- **Long press:** hold for 5000 clocks → long_press 2000 clocks after the press edge; nothing further while held or on release.
- **Double press:**
  - Press 300, release 400, press 200, release → one double_press, 1 clock after the second release edge, and no short_press.
  - Repeat with the second press sampled exactly at gap count 999 → double_press, not short_press.
- **Boundaries:**
  - Release sampled at exactly t0+2000 → no long_press; short_press follows 1000 clocks later.
  - Release at t0+2001 → long_press only.
- **Held through reset:** value_in=0 during and after rst → no events until a release, then a full new press cycle behaves normally. Separately, rst asserted in GAP at count 500 → no short_press is ever produced.
